us_arp_tx: RTL

- ARP frame generator directly downstream of the ARP table.
- Accepts the table's request handshake (arp_request_req/arp_request_ack) and replies requested by the ARP RX path.
- Serialises one Ethernet+ARP frame per accepted job onto a 64-bit AXI-Stream-style bus toward the TX MAC arbiter. FCS is added downstream.

---
 rtl/us_arp_pkg.sv | 34 +++
 rtl/us_arp_frame_rom.sv | 65 ++++++
 rtl/us_arp_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/us_arp_pkg.sv
// Shared constants and helpers for the ARP frame generator.
// Frame lengths exclude FCS, which is appended downstream.
package us_arp_pkg;

    localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN_ETH      = 8'h06;
    localparam logic [7:0]  PLEN_IPV4     = 8'h04;
    localparam logic [15:0] OPER_REQ      = 16'h0001;
    localparam logic [15:0] OPER_REPLY    = 16'h0002;
    localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

    localparam int unsigned FRAME_LEN     = 42;
    localparam int unsigned FRAME_LEN_PAD = 60;
    localparam int unsigned BEAT_BYTES    = 8;

    typedef enum logic {StIdle, StSend} arp_tx_state_e;

    function automatic logic [2:0] last_beat(input bit pad);
        int unsigned len;
        len = pad ? FRAME_LEN_PAD : FRAME_LEN;
        return 3'((len + BEAT_BYTES - 1) / BEAT_BYTES - 1);
    endfunction

    function automatic logic [7:0] last_keep(input bit pad);
        int unsigned len;
        int unsigned rem;
        len = pad ? FRAME_LEN_PAD : FRAME_LEN;
        rem = len % BEAT_BYTES;
        return (rem == 0) ? 8'hFF : 8'((16'h1 << rem) - 16'h1);
    endfunction

endpackage

// File: rtl/us_arp_frame_rom.sv
// Combinational beat formatter: lays out the Ethernet+ARP frame from the
// latched job fields and selects the 8-byte slice for the current beat.
module us_arp_frame_rom
    import us_arp_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic [2:0]  beat_cnt,
    input  logic        is_reply,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [47:0] peer_mac,
    input  logic [31:0] target_ip,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast
);

    localparam logic [2:0] LAST_BEAT = last_beat(PAD_EN);
    localparam logic [7:0] LAST_KEEP = last_keep(PAD_EN);

    logic [47:0] eth_dst;
    logic [47:0] tgt_mac;
    logic [15:0] oper;
    logic [7:0]  frame_b [64];

    always_comb begin
        eth_dst = is_reply ? peer_mac : MAC_BCAST;
        tgt_mac = is_reply ? peer_mac : 48'h0;
        oper    = is_reply ? OPER_REPLY : OPER_REQ;
        // Anything not written below is padding and stays zero.
        for (int i = 0; i < 64; i++) begin
            frame_b[i] = 8'h00;
        end
        for (int i = 0; i < 6; i++) begin
            frame_b[i]      = eth_dst[47 - 8*i -: 8];
            frame_b[6 + i]  = local_mac[47 - 8*i -: 8];
            frame_b[22 + i] = local_mac[47 - 8*i -: 8];
            frame_b[32 + i] = tgt_mac[47 - 8*i -: 8];
        end
        frame_b[12] = ARP_ETHERTYPE[15:8];
        frame_b[13] = ARP_ETHERTYPE[7:0];
        frame_b[14] = HTYPE_ETH[15:8];
        frame_b[15] = HTYPE_ETH[7:0];
        frame_b[16] = PTYPE_IPV4[15:8];
        frame_b[17] = PTYPE_IPV4[7:0];
        frame_b[18] = HLEN_ETH;
        frame_b[19] = PLEN_IPV4;
        frame_b[20] = oper[15:8];
        frame_b[21] = oper[7:0];
        for (int i = 0; i < 4; i++) begin
            frame_b[28 + i] = local_ip[31 - 8*i -: 8];
            frame_b[38 + i] = target_ip[31 - 8*i -: 8];
        end
    end

    always_comb begin
        tlast = (beat_cnt == LAST_BEAT);
        tkeep = tlast ? LAST_KEEP : 8'hFF;
        for (int b = 0; b < 8; b++) begin
            tdata[8*b +: 8] = tkeep[b] ? frame_b[{beat_cnt, 3'(b)}] : 8'h00;
        end
    end

endmodule

// File: rtl/us_arp_tx.sv
// ARP frame generator: arbitrates table requests against RX-path replies,
// latches the job fields and streams one frame per job as 64-bit beats.
module us_arp_tx
    import us_arp_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    input  logic [31:0] dst_ip_addr,
    input  logic        arp_request_req,
    output logic        arp_request_ack,
    input  logic        reply_req,
    input  logic [47:0] reply_dst_mac,
    input  logic [31:0] reply_dst_ip,
    output logic        reply_ack,
    output logic [63:0] tx_tdata,
    output logic [7:0]  tx_tkeep,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        tx_tlast,
    output logic        busy
);

    arp_tx_state_e state_q, state_d;
    logic [2:0]    beat_cnt_q, beat_cnt_d;
    logic          is_reply_q, is_reply_d;
    logic [47:0]   local_mac_q, local_mac_d;
    logic [31:0]   local_ip_q, local_ip_d;
    logic [47:0]   peer_mac_q, peer_mac_d;
    logic [31:0]   target_ip_q, target_ip_d;
    logic          req_ack_q, req_ack_d;
    logic          rep_ack_q, rep_ack_d;

    logic [63:0] rom_tdata;
    logic [7:0]  rom_tkeep;
    logic        rom_tlast;
    logic        send;

    us_arp_frame_rom #(
        .PAD_EN(PAD_EN)
    ) u_frame_rom (
        .beat_cnt (beat_cnt_q),
        .is_reply (is_reply_q),
        .local_mac(local_mac_q),
        .local_ip (local_ip_q),
        .peer_mac (peer_mac_q),
        .target_ip(target_ip_q),
        .tdata    (rom_tdata),
        .tkeep    (rom_tkeep),
        .tlast    (rom_tlast)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            beat_cnt_q  <= 3'd0;
            is_reply_q  <= 1'b0;
            local_mac_q <= 48'h0;
            local_ip_q  <= 32'h0;
            peer_mac_q  <= 48'h0;
            target_ip_q <= 32'h0;
            req_ack_q   <= 1'b0;
            rep_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            is_reply_q  <= is_reply_d;
            local_mac_q <= local_mac_d;
            local_ip_q  <= local_ip_d;
            peer_mac_q  <= peer_mac_d;
            target_ip_q <= target_ip_d;
            req_ack_q   <= req_ack_d;
            rep_ack_q   <= rep_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        is_reply_d  = is_reply_q;
        local_mac_d = local_mac_q;
        local_ip_d  = local_ip_q;
        peer_mac_d  = peer_mac_q;
        target_ip_d = target_ip_q;
        req_ack_d   = 1'b0;
        rep_ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Replies win; a concurrent table request stays pending.
                if (reply_req || arp_request_req) begin
                    state_d     = StSend;
                    beat_cnt_d  = 3'd0;
                    local_mac_d = local_mac_addr;
                    local_ip_d  = local_ip_addr;
                    is_reply_d  = reply_req;
                    if (reply_req) begin
                        rep_ack_d   = 1'b1;
                        peer_mac_d  = reply_dst_mac;
                        target_ip_d = reply_dst_ip;
                    end else begin
                        req_ack_d   = 1'b1;
                        peer_mac_d  = 48'h0;
                        target_ip_d = dst_ip_addr;
                    end
                end
            end
            StSend: begin
                if (tx_tready) begin
                    if (rom_tlast) begin
                        state_d    = StIdle;
                        beat_cnt_d = 3'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        send            = (state_q == StSend);
        tx_tvalid       = send;
        busy            = send;
        tx_tdata        = send ? rom_tdata : 64'h0;
        tx_tkeep        = send ? rom_tkeep : 8'h00;
        tx_tlast        = send && rom_tlast;
        arp_request_ack = req_ack_q;
        reply_ack       = rep_ack_q;
    end

endmodule
